// File: rtl/huffman_build_ctrl.sv
// huffman_build_ctrl: frame sequencer for the 4-symbol Huffman datapath (optional BUILD watchdog via HUFF_CTRL_TIMEOUT_EN)
module huffman_build_ctrl #(
  parameter int CNT_W       = 4,
  parameter int BUILD_MIN   = 2,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             start,
  input  logic             sym_valid,
  input  logic [1:0]       sym,
  input  logic             sym_last,
  input  logic             build_done,
  input  logic             out_ready,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] cnt_A,
  output logic [CNT_W-1:0] cnt_B,
  output logic [CNT_W-1:0] cnt_C,
  output logic [CNT_W-1:0] cnt_D,
  output logic             sym_ready,
  output logic             table_valid,
  output logic             sat,
  output logic             err
);
  localparam int LIM  = TIMEOUT_CYC > BUILD_MIN ? TIMEOUT_CYC : BUILD_MIN;
  localparam int BC_W = $clog2(LIM + 1);
  typedef enum logic [1:0] {IDLE = 2'b00, COUNT = 2'b01, BUILD = 2'b10, OUT = 2'b11} state_t;
  state_t cur, nxt;
  logic [BC_W-1:0] bc;
  logic [CNT_W-1:0] cnt [4];
  logic done_ok, tmo, go;
  assign go      = cur == IDLE && start;
  assign done_ok = build_done && bc >= BC_W'(BUILD_MIN - 1);
`ifdef HUFF_CTRL_TIMEOUT_EN
  assign tmo = bc == BC_W'(TIMEOUT_CYC - 1);
`else
  assign tmo = 1'b0;
`endif
  assign state       = cur;
  assign sym_ready   = cur == COUNT;
  assign table_valid = cur == OUT;
  assign cnt_A = cnt[0];
  assign cnt_B = cnt[1];
  assign cnt_C = cnt[2];
  assign cnt_D = cnt[3];
  // phase register
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) cur <= IDLE;
    else cur <= nxt;
  // next phase; build_done takes priority over the watchdog
  always_comb begin
    nxt = cur;
    nxt = go ? COUNT :
          (cur == COUNT && sym_valid && sym_last) ? BUILD :
          (cur == BUILD && done_ok) ? OUT :
          (cur == BUILD && tmo) ? IDLE :
          (cur == OUT && out_ready) ? IDLE : cur;
  end
  // BUILD residency counter, zero outside BUILD and saturating inside
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) bc <= '0;
    else bc <= cur != BUILD ? '0 : (&bc ? bc : bc + 1'b1);
  // frequency counters and sticky saturation flag
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      cnt <= '{default: '0};
      sat <= 1'b0;
    end else if (go) begin
      cnt <= '{default: '0};
      sat <= 1'b0;
    end else if (cur == COUNT && sym_valid) begin
      if (&cnt[sym]) sat <= 1'b1;
      else cnt[sym] <= cnt[sym] + 1'b1;
    end
`ifdef HUFF_CTRL_TIMEOUT_EN
  // sticky watchdog error, cleared by an accepted start
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) err <= 1'b0;
    else if (go) err <= 1'b0;
    else if (cur == BUILD && tmo && !done_ok) err <= 1'b1;
`else
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_huffman_build_ctrl.sv
// tb_huffman_build_ctrl: directed checks of the Huffman frame sequencer
module tb_huffman_build_ctrl;
  logic CLK = 1'b0, nRST = 1'b0;
  logic start = 0, sym_valid = 0, sym_last = 0, build_done = 0, out_ready = 0;
  logic [1:0] sym = 0;
  logic [1:0] state;
  logic [3:0] cnt_A, cnt_B, cnt_C, cnt_D;
  logic sym_ready, table_valid, sat, err;
  int tests = 0, fails = 0;

  huffman_build_ctrl dut (
    .CLK(CLK), .nRST(nRST), .start(start), .sym_valid(sym_valid), .sym(sym),
    .sym_last(sym_last), .build_done(build_done), .out_ready(out_ready),
    .state(state), .cnt_A(cnt_A), .cnt_B(cnt_B), .cnt_C(cnt_C), .cnt_D(cnt_D),
    .sym_ready(sym_ready), .table_valid(table_valid), .sat(sat), .err(err)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [1:0] s, input logic last);
    sym_valid = 1; sym = s; sym_last = last;
    tick();
    sym_valid = 0; sym_last = 0;
  endtask

  initial begin
    logic [1:0] stream [7];
    stream = '{0, 1, 1, 2, 3, 3, 3};
    #2;
    check("rst_state", state, 0);
    check("rst_cnts", {cnt_A, cnt_B, cnt_C, cnt_D}, 0);
    check("rst_flags", {sym_ready, table_valid, sat, err}, 0);
    tick();
    nRST = 1;
    tick();
    check("idle_hold", state, 0);
    start = 1; tick(); start = 0;
    check("start_state", state, 1);
    check("start_sym_ready", sym_ready, 1);
    for (int i = 0; i < 6; i++) send(stream[i], 0);
    check("count_still", state, 1);
    sym_last = 1; tick(); sym_last = 0;
    check("last_no_valid", state, 1);
    send(stream[6], 1);
    check("build_entry", state, 2);
    check("cnt_A", cnt_A, 1);
    check("cnt_B", cnt_B, 2);
    check("cnt_C", cnt_C, 1);
    check("cnt_D", cnt_D, 3);
    check("build_sym_ready", sym_ready, 0);
    build_done = 1;
    tick();
    check("build_min_hold", state, 2);
    tick();
    build_done = 0;
    check("build_exit", state, 3);
    start = 1;
    for (int i = 0; i < 5; i++) begin
      check("out_wait_valid", table_valid, 1);
      tick();
    end
    start = 0;
    check("out_sixth_valid", table_valid, 1);
    out_ready = 1;
    tick();
    out_ready = 0;
    check("out_to_idle", state, 0);
    check("idle_valid_low", table_valid, 0);
    check("idle_cnt_D_kept", cnt_D, 3);
    check("idle_cnt_B_kept", cnt_B, 2);
    start = 1; tick(); start = 0;
    check("restart_cnts", {cnt_A, cnt_B, cnt_C, cnt_D}, 0);
    send(0, 1);
    check("pulse_build", state, 2);
    build_done = 1; tick(); build_done = 0;
    check("pulse_c1", state, 2);
    tick(); tick();
    check("pulse_not_latched", state, 2);
    build_done = 1; tick(); build_done = 0;
    check("late_done_out", state, 3);
    out_ready = 1; tick(); out_ready = 0;
    check("late_idle", state, 0);
    start = 1; tick(); start = 0;
    for (int i = 0; i < 15; i++) send(0, 0);
    check("sat_15_cnt", cnt_A, 15);
    check("sat_15_flag", sat, 0);
    send(0, 0);
    send(0, 1);
    check("sat_17_cnt", cnt_A, 15);
    check("sat_17_flag", sat, 1);
    check("sat_last_build", state, 2);
    build_done = 1; tick(); tick(); build_done = 0;
    out_ready = 1; tick(); out_ready = 0;
    check("sat_idle_sticky", sat, 1);
    start = 1; tick(); start = 0;
    check("sat_cleared", sat, 0);
    check("sat_cnt_cleared", cnt_A, 0);
    send(1, 0);
    check("mid_cnt_B", cnt_B, 1);
    #2 nRST = 0;
    #1;
    check("async_state", state, 0);
    check("async_cnt_B", cnt_B, 0);
    check("async_sym_ready", sym_ready, 0);
    tick();
    nRST = 1;
    start = 1; tick(); start = 0;
    send(0, 1);
    check("wd_build", state, 2);
`ifdef HUFF_CTRL_TIMEOUT_EN
    repeat (63) tick();
    check("wd_63", state, 2);
    check("wd_63_err", err, 0);
    tick();
    check("wd_idle", state, 0);
    check("wd_err", err, 1);
    check("wd_cnt_held", cnt_A, 1);
    start = 1; tick(); start = 0;
    check("wd_err_clr", err, 0);
`else
    repeat (200) tick();
    check("nowd_build", state, 2);
    check("nowd_err", err, 0);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
